// File: rtl/router_in_arb.sv
// Round-robin packet-source arbiter that feeds a byte-wide router input, then appends a parity byte and a length check.
// Data and ready are combinational from the granted source; busy stalls XFER and extends GAP, but never PARITY.
module router_in_arb #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [8*NREQ-1:0] src_data,
  input  logic [NREQ-1:0]   src_valid,
  input  logic [NREQ-1:0]   src_last,
  output logic [NREQ-1:0]   src_ready,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        data_in,
  output logic              pkt_valid,
  input  logic              busy,
  input  logic              error,
  output logic              len_err,
  output logic [7:0]        err_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, XFER, PARITY, GAP} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [7:0]      par_q, par_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [5:0]      len_q, len_d;
  logic            hdr_seen_q, hdr_seen_d;
  logic            hdr_last_q, hdr_last_d;
  logic            par2_q, par2_d;
  logic            err_prev_q;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic [PW-1:0]   pick;
  logic [PW-1:0]   rr_idx;
  logic            any_req;
  logic [7:0]      g_byte;

  // Search starts one past the last grantee; the index wraps because NREQ is a power of two.
  always_comb begin
    pick    = ptr_q;
    any_req = 1'b0;
    rr_idx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      rr_idx = ptr_q + PW'(i);
      if (!any_req && src_valid[rr_idx]) begin
        any_req = 1'b1;
        pick    = rr_idx;
      end
    end
  end

  assign g_byte = src_data[{ptr_q, 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    par_d      = par_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    hdr_seen_d = hdr_seen_q;
    hdr_last_d = hdr_last_q;
    par2_d     = par2_q;
    src_ready  = '0;
    data_in    = 8'h00;
    pkt_valid  = 1'b0;
    len_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          ptr_d       = pick;
          par_d       = 8'h00;
          cnt_d       = 6'd0;
          len_d       = 6'd0;
          hdr_seen_d  = 1'b0;
          hdr_last_d  = 1'b0;
          par2_d      = 1'b0;
          state_d     = XFER;
        end
      end
      XFER: begin
        src_ready = gnt_q & {NREQ{~busy}};
        data_in   = g_byte;
        pkt_valid = src_valid[ptr_q];
        if (src_valid[ptr_q] && !busy) begin
          par_d = par_q ^ g_byte;
          if (!hdr_seen_q) begin
            hdr_seen_d = 1'b1;
            len_d      = g_byte[7:2];
            hdr_last_d = src_last[ptr_q];
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
          if (src_last[ptr_q]) state_d = PARITY;
        end
      end
      PARITY: begin
        data_in = par_q;
        if (!par2_q) begin
          len_err = hdr_last_q || (len_q == 6'd0) || (cnt_q != len_q);
          par2_d  = 1'b1;
        end else begin
          par2_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (!busy) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_cnt_d = (error && !err_prev_q && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_q      <= PW'(NREQ - 1);
      par_q      <= 8'h00;
      cnt_q      <= 6'd0;
      len_q      <= 6'd0;
      hdr_seen_q <= 1'b0;
      hdr_last_q <= 1'b0;
      par2_q     <= 1'b0;
      err_prev_q <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      par_q      <= par_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      hdr_seen_q <= hdr_seen_d;
      hdr_last_q <= hdr_last_d;
      par2_q     <= par2_d;
      err_prev_q <= error;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign err_cnt = err_cnt_q;

endmodule
